// File: rtl/div_sched_pkg.sv
// Shared definitions for the two-requester divide scheduler:
// FSM encoding, error-response constants and the saturating counter helper.
package div_sched_pkg;

  // Scheduler FSM encoding (2 bits).
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Width of the WAIT-cycle counter.
  localparam int CNT_W = 8;

  // Quotient nibble reported on a divide-by-zero (remainder nibble carries the dividend).
  localparam logic [3:0] DZ_QUOT = 4'hF;

  // Response data reported when the divider times out.
  localparam logic [7:0] TMO_DATA = 8'h00;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/div_sched_rr_arb2.sv
// Two-way round-robin arbiter. 'last' names the requester served most
// recently; on a tie the other requester wins. Purely combinational.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  // Lone requests win outright; simultaneous requests go to the one not served last.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/div_sched.sv
// Divide scheduler: arbitrates two requesters onto one shared divider,
// handles divide-by-zero locally and aborts a divide that runs past TIMEOUT
// WAIT cycles. All outputs come from registers or from the registered state.
module div_sched
  import div_sched_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] dividend0,
  input  logic [3:0] divisor0,
  input  logic [3:0] dividend1,
  input  logic [3:0] divisor1,
  output logic       div_start,
  output logic [3:0] div_dividend,
  output logic [3:0] div_divisor,
  input  logic       div_done,
  input  logic [3:0] div_quotient,
  input  logic [3:0] div_remainder,
  output logic       rsp_valid0,
  output logic       rsp_valid1,
  output logic [7:0] rsp_data,
  output logic       rsp_err
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic             winner_q, winner_d;     // id of the granted requester
  logic             last_q, last_d;         // id served most recently
  logic [3:0]       dividend_q, dividend_d;
  logic [3:0]       divisor_q, divisor_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;

  logic [1:0]       req_vec;
  logic [1:0]       grant;
  logic [1:0]       rsp_valid_vec;
  logic [CNT_W-1:0] cnt_inc;

  assign req_vec = {req1, req0};
  assign cnt_inc = sat_inc(cnt_q);

  rr_arb2 u_arb (
    .req   (req_vec),
    .last  (last_q),
    .grant (grant)
  );

  // Next-state logic for the scheduler FSM and its datapath registers.
  always_comb begin
    state_d    = state_q;
    winner_d   = winner_q;
    last_d     = last_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (|req_vec) begin
          winner_d   = grant[1];
          dividend_d = grant[1] ? dividend1 : dividend0;
          divisor_d  = grant[1] ? divisor1  : divisor0;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (divisor_q != 4'd0) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end else begin
          // Answer a divide-by-zero locally without touching the divider.
          rsp_data_d = {dividend_q, DZ_QUOT};
          rsp_err_d  = 1'b1;
          state_d    = ST_RESP;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_inc;
        // div_done is tested first so a completion on the timeout cycle still counts.
        if (div_done) begin
          rsp_data_d = {div_remainder, div_quotient};
          rsp_err_d  = 1'b0;
          state_d    = ST_RESP;
        end else if (cnt_inc >= TMO) begin
          rsp_data_d = TMO_DATA;
          rsp_err_d  = 1'b1;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        last_d  = winner_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset favours req0 by marking req1 as last served.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      winner_q   <= 1'b0;
      last_q     <= 1'b1;
      dividend_q <= 4'd0;
      divisor_q  <= 4'd0;
      cnt_q      <= '0;
      rsp_data_q <= 8'h00;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      winner_q   <= winner_d;
      last_q     <= last_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // One response strobe per requester, decoded from RESP and the latched winner.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
    assign rsp_valid_vec[gi] = (state_q == ST_RESP) && (winner_q == 1'(gi));
  end

  assign div_start    = (state_q == ST_ISSUE) && (divisor_q != 4'd0);
  assign div_dividend = dividend_q;
  assign div_divisor  = divisor_q;
  assign rsp_valid0   = rsp_valid_vec[0];
  assign rsp_valid1   = rsp_valid_vec[1];
  assign rsp_data     = rsp_data_q;
  assign rsp_err      = rsp_err_q;

endmodule

// File: doc/div_sched.md
DIV_SCHED -- requirements
Module: div_sched

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum WAIT cycles before abort; range 1..255.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 req0, req1  input  1 each  requester divide request; held high until the matching rsp_valid.
REQ-005 dividend0, divisor0, dividend1, divisor1  input  4 each  requester operands; stable while req is high.
REQ-006 div_start  output  1  one-cycle start pulse to the shared divider datapath.
REQ-007 div_dividend, div_divisor  output  4 each  operands to the divider; held from ISSUE until RESP.
REQ-008 div_done  input  1  divider completion pulse.
REQ-009 div_quotient, div_remainder  input  4 each  divider results; valid when div_done is high.
REQ-010 rsp_valid0, rsp_valid1  output  1 each  one-cycle response pulse to the granted requester.
REQ-011 rsp_data  output  8  {remainder[3:0], quotient[3:0]}; valid with rsp_valid.
REQ-012 rsp_err  output  1  error flag (divide-by-zero or timeout); valid with rsp_valid.

Function
REQ-013 FSM states: IDLE, ISSUE, WAIT, RESP; all outputs are registered or state-decoded, with no combinational input-to-output path.
REQ-014 IDLE: if any req is high, arbitrate, latch the winner id and its operands, and go to ISSUE; otherwise stay in IDLE.
REQ-015 Arbitration is round-robin over 2: a lone request wins; if both are high, the requester not served last wins; after reset, req0 has priority.
REQ-016 ISSUE, divisor != 0: div_start=1 for exactly this cycle; next state is WAIT; the timeout counter clears to 0.
REQ-017 ISSUE, divisor == 0: no div_start; rsp_data <= {dividend, 4'hF}; rsp_err <= 1; next state is RESP.
REQ-018 WAIT: the counter increments each cycle; div_done=1 captures {div_remainder, div_quotient}, sets rsp_err <= 0, and moves to RESP.
REQ-019 WAIT: when the counter reaches TIMEOUT with no div_done, rsp_data <= 8'h00, rsp_err <= 1, and the FSM moves to RESP.
REQ-020 If div_done and the timeout coincide in the same cycle, div_done wins.
REQ-021 RESP: rsp_validN=1 for the latched winner only, for one cycle; the round-robin pointer updates to the winner; next state is IDLE.
REQ-022 Latency: a request seen in IDLE at cycle n gives div_start at n+1; div_done at cycle m gives rsp_valid at m+1; divide-by-zero gives rsp_valid at n+2.
REQ-023 div_done outside WAIT is ignored.
REQ-024 The operands and the winner are latched at grant; a requester deasserting req before its response still receives rsp_valid.
REQ-025 A req still high in the cycle after its rsp_valid is treated as a new request.
REQ-026 The counter is 8 bits and saturates; it never wraps.
REQ-027 rsp_data and rsp_err hold their last value outside RESP.

Reset
REQ-028 resetn low asynchronously forces: state IDLE; div_start=0; rsp_valid0/1=0; rsp_data=8'h00; rsp_err=0; div_dividend/div_divisor=0; counter=0; pointer set to favour req0.
REQ-029 Reset mid-operation abandons the transaction with no response; a late div_done after reset release is ignored.

Structure
REQ-030 A shared package holds the state encoding (2-bit enum) and the error data constants 4'hF and 8'h00.
REQ-031 The 2-way round-robin arbiter is a sub-module named rr_arb2, with inputs req[1:0] and last, and output a one-hot grant.

Verification
REQ-032 req0 with 13/4; the model divider asserts done 4 cycles after start with q=3, r=1 -> one div_start with 13/4; rsp_valid0 with rsp_data=8'h13, rsp_err=0.
REQ-033 req0 and req1 asserted together after reset, held until served, then both re-asserted -> service order 0, 1, 0; each response pulses only its own rsp_valid.
REQ-034 req1 with 9/0 -> no div_start; rsp_valid1 two cycles after the request with rsp_data=8'h9F, rsp_err=1.
REQ-035 req0 with 7/2 and the divider never completes, TIMEOUT=15 -> rsp_valid0 with rsp_data=8'h00, rsp_err=1 after 15 WAIT cycles; the next request is served normally.
REQ-036 resetn pulsed low during WAIT, then div_done arrives -> outputs are at reset values immediately, no rsp_valid occurs, and a following req1 of 15/3 returns 8'h05.
REQ-037 div_done in the same cycle as the timeout -> rsp_err=0 and rsp_data equals the divider result.
